zap_tlb_refill_ctrl: RTL
========================

// Module: zap_tlb_refill_ctrl
//
// PURPOSE
//  Write-side sequencer for a single-cycle-invalidate tag RAM (TLB tag/data store).
//  Accepts a miss, issues one walk request, and writes the returned entry into the tag RAM.
//  Drives the RAM write port (wen/waddr/wdata). Guarantees that an invalidate issued while a
//  walk is outstanding never lets a stale entry land in the RAM.
//
// PARAMETERS
//  DEPTH    32   tag RAM entries; power of 2, >= 2
//  WIDTH    32   entry width written to RAM (valid bit excluded)
//  VA_W     32   miss virtual address width
//  IDX_LSB  12   LSB of the index field in the VA; IDX_LSB + $clog2(DEPTH) <= VA_W
//  TIMEOUT  255  walk-ack watchdog in cycles; 1..65535; exhaustion -> fault
//
// PORTS
//  i_clk          in   1              clock
//  i_reset        in   1              synchronous, active-high reset
//  i_miss         in   1              miss request, sampled only in IDLE
//  i_miss_va      in   VA_W           miss address, captured with i_miss
//  o_busy         out  1              high in every non-IDLE state
//  o_walk_req     out  1              walk request, level, held until ack
//  o_walk_va      out  VA_W           captured VA, stable while o_walk_req
//  i_walk_ack     in   1              walk complete; data/fault valid this cycle
//  i_walk_data    in   WIDTH          entry to install
//  i_walk_fault   in   1              walk faulted; do not install
//  i_inv          in   1              TLB invalidate; same signal feeds the RAM's i_inv
//  o_wen          out  1              RAM write enable, 1-cycle pulse
//  o_waddr        out  $clog2(DEPTH)  RAM write index
//  o_wdata        out  WIDTH          RAM write data
//  o_fill_done    out  1              1-cycle pulse: entry installed
//  o_fault        out  1              1-cycle pulse: walk fault or watchdog expiry
//
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; kill flag 0; watchdog 0. Reset overrides every state.
//  - Index = va[IDX_LSB +: $clog2(DEPTH)], taken from the captured VA.
//  - IDLE: if i_miss, capture VA, clear kill flag, load watchdog=TIMEOUT, and go to REQ.
//    i_miss while not IDLE is ignored; the requester re-asserts it.
//  - REQ: o_walk_req=1. The watchdog decrements each cycle without ack.
//      ack & fault            -> FAULT
//      ack & ~fault & kill    -> IDLE; data dropped; no wen, no done
//      ack & ~fault & ~kill   -> WRITE; latch i_walk_data
//      watchdog==0 & ~ack     -> FAULT; o_walk_req drops; a late ack is ignored in IDLE
//  - i_inv in REQ sets the kill flag. i_inv with ack in the same cycle also counts as kill.
//  - WRITE: o_wen=~i_inv, o_waddr=index, o_wdata=latched data.
//      ~i_inv -> DONE
//      i_inv  -> IDLE silently; the RAM clears DAV in the same cycle, and a write must not
//               race it.
//  - DONE: o_fill_done=1 for one cycle -> IDLE. The entry is readable with DAV on the
//    following RAM read (1-cycle read latency).
//  - FAULT: o_fault=1 for one cycle -> IDLE. RAM untouched.
//  - Latency, miss to wen: 1 (IDLE->REQ) + walk latency (ack cycle) + 1. Minimum: ack in the
//    first REQ cycle gives wen 2 cycles after i_miss, and o_fill_done 3 cycles after.
//  - Outputs are registered from the state. o_wen is the only output gated combinationally,
//    by i_inv.
//  - i_inv in IDLE, DONE or FAULT has no effect on the FSM.
//
// STRUCTURE
//  - zap_tlb_pkg: typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, FAULT}
//    zap_tlb_refill_state_t; index-width helper function.
//  - Single module. The watchdog counter is inline; no sub-module.
//  - Instantiated beside zap_mem_inv_block: o_wen/o_waddr/o_wdata -> i_wen/i_waddr/i_wdata,
//    with a shared i_inv.
//
// TESTING
//  1. Reset mid-REQ (va=0x0000_3000): next cycle o_walk_req=0, o_busy=0; all outputs 0.
//  2. Miss va=0x0000_5000 (DEPTH=32), ack on 1st REQ cycle, data=0xCAFE_0001 -> o_wen at
//     cycle 2, waddr=5, wdata=0xCAFE_0001; o_fill_done at cycle 3.
//  3. Miss, then i_inv 2 cycles before ack -> no o_wen, no done/fault; back in IDLE cycle
//     after ack.
//  4. Miss, ack, i_inv asserted in the WRITE cycle -> o_wen=0 that cycle; IDLE next; no done.
//  5. Miss, ack with i_walk_fault=1 -> o_fault 1-cycle pulse; o_wen never asserted.
//  6. TIMEOUT=4, no ack -> o_walk_req high 5 cycles, then o_fault; late ack ignored; a new
//     miss is accepted.

Source files
------------

// File: rtl/zap_tlb_pkg.sv
// Shared types and helpers for the TLB refill write-side sequencer.
package zap_tlb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    DONE,
    FAULT
  } zap_tlb_refill_state_t;

  // Wide enough for the largest legal watchdog load value.
  localparam int unsigned WdogW = 16;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/zap_tlb_refill_ctrl.sv
// Refill sequencer: takes a TLB miss, issues one walk, and installs the returned entry in the tag
// RAM unless an invalidate arrived while the walk was outstanding.
module zap_tlb_refill_ctrl
  import zap_tlb_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned VA_W    = 32,
  parameter int unsigned IDX_LSB = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_miss,
  input  logic [VA_W-1:0]               i_miss_va,
  output logic                          o_busy,
  output logic                          o_walk_req,
  output logic [VA_W-1:0]               o_walk_va,
  input  logic                          i_walk_ack,
  input  logic [WIDTH-1:0]              i_walk_data,
  input  logic                          i_walk_fault,
  input  logic                          i_inv,
  output logic                          o_wen,
  output logic [idx_width(DEPTH)-1:0]   o_waddr,
  output logic [WIDTH-1:0]              o_wdata,
  output logic                          o_fill_done,
  output logic                          o_fault
);

  localparam int unsigned IdxW = idx_width(DEPTH);
  localparam logic [WdogW-1:0] WdogInit = WdogW'(TIMEOUT);
  localparam logic [WdogW-1:0] WdogOne  = WdogW'(1);

  zap_tlb_refill_state_t state_q, state_d;
  logic [VA_W-1:0]       va_q, va_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  kill_q, kill_d;
  logic [WdogW-1:0]      wdog_q, wdog_d;
  logic [IdxW-1:0]       idx;

  assign idx = va_q[IDX_LSB +: IdxW];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      va_q    <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    data_d  = data_q;
    kill_d  = kill_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (i_miss) begin
          va_d    = i_miss_va;
          kill_d  = 1'b0;
          wdog_d  = WdogInit;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_inv) begin
          kill_d = 1'b1;
        end
        if (i_walk_ack) begin
          if (i_walk_fault) begin
            state_d = FAULT;
          end else if (kill_q || i_inv) begin
            // Entry may predate the invalidate; dropping it keeps stale data out of the RAM.
            state_d = IDLE;
          end else begin
            data_d  = i_walk_data;
            state_d = WRITE;
          end
        end else if (wdog_q == '0) begin
          state_d = FAULT;
        end else begin
          wdog_d = wdog_q - WdogOne;
        end
      end
      WRITE: begin
        // The RAM clears DAV on i_inv this cycle, so the write is abandoned rather than raced.
        state_d = i_inv ? IDLE : DONE;
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != IDLE);
    o_walk_req  = (state_q == REQ);
    o_walk_va   = va_q;
    o_wen       = (state_q == WRITE) && !i_inv;
    o_waddr     = (state_q == WRITE) ? idx : '0;
    o_wdata     = (state_q == WRITE) ? data_q : '0;
    o_fill_done = (state_q == DONE);
    o_fault     = (state_q == FAULT);
  end

endmodule
